id_ex_stage: RTL and testbench

- ID/EX pipeline register and operand-select stage that directly feeds the 3-bit-op ALU.
- Captures decoded ID-stage fields each cycle and translates the main-decoder ALU class plus funct into the ALU op encoding.
- Resolves EX/MEM and MEM/WB forwarding and drives alu_op/alu_in1/alu_in2.
- Detects load-use hazards and inserts bubbles.

---
 rtl/id_ex_stage.sv | 173 +++++++++++++++++
 tb/tb_id_ex_stage.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with ALU op translation, EX/MEM and MEM/WB operand
// forwarding, and load-use hazard detection feeding the 3-bit-op ALU.
module id_ex_stage #(
    parameter int W  = 32,
    parameter int RA = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                stall,
    input  logic                flush,
    input  logic                id_valid,
    input  logic [W-1:0]        id_rs_val,
    input  logic [W-1:0]        id_rt_val,
    input  logic [W-1:0]        id_imm,
    input  logic [RA-1:0]       id_rs,
    input  logic [RA-1:0]       id_rt,
    input  logic [RA-1:0]       id_rd,
    input  logic [4:0]          id_shamt,
    input  logic [5:0]          id_funct,
    input  logic [1:0]          id_alu_class,
    input  logic                id_alu_src,
    input  logic                id_uses_rt,
    input  logic                id_reg_write,
    input  logic                id_mem_read,
    input  logic                id_mem_write,
    input  logic                exmem_reg_write,
    input  logic [RA-1:0]       exmem_rd,
    input  logic [W-1:0]        exmem_result,
    input  logic                memwb_reg_write,
    input  logic [RA-1:0]       memwb_rd,
    input  logic [W-1:0]        memwb_result,
    output logic [2:0]          alu_op,
    output logic signed [W-1:0] alu_in1,
    output logic signed [W-1:0] alu_in2,
    output logic [W-1:0]        ex_store_data,
    output logic [RA-1:0]       ex_dest,
    output logic                ex_valid,
    output logic                ex_reg_write,
    output logic                ex_mem_read,
    output logic                ex_mem_write,
    output logic                load_use_stall,
    output logic                illegal_funct
);

    typedef struct packed {
        logic          valid;
        logic          reg_write;
        logic          mem_read;
        logic          mem_write;
        logic          alu_src;
        logic          shift;
        logic          illegal;
        logic [2:0]    op;
        logic [4:0]    shamt;
        logic [RA-1:0] rs;
        logic [RA-1:0] rt;
        logic [RA-1:0] dest;
        logic [W-1:0]  rs_val;
        logic [W-1:0]  rt_val;
        logic [W-1:0]  imm;
    } ex_t;

    localparam ex_t EX_BUBBLE = '{op: 3'b010, default: '0};

    ex_t        ex_q;
    ex_t        cap;
    logic [2:0] dec_op;
    logic       dec_shift;
    logic       dec_illegal;
    logic [W-1:0] fwd_rs;
    logic [W-1:0] fwd_rt;

    always_comb begin
        dec_op      = 3'b010;
        dec_shift   = 1'b0;
        dec_illegal = 1'b0;
        case (id_alu_class)
            2'b00: dec_op = 3'b010;
            2'b01: dec_op = 3'b110;
            2'b11: dec_op = 3'b001;
            default: begin
                case (id_funct)
                    6'h20, 6'h21: dec_op = 3'b010;
                    6'h22, 6'h23: dec_op = 3'b110;
                    6'h24:        dec_op = 3'b000;
                    6'h25:        dec_op = 3'b001;
                    6'h2A:        dec_op = 3'b111;
                    6'h00: begin
                        dec_op    = 3'b100;
                        dec_shift = 1'b1;
                    end
                    6'h02: begin
                        dec_op    = 3'b101;
                        dec_shift = 1'b1;
                    end
                    default: begin
                        dec_op      = 3'b011;
                        dec_illegal = 1'b1;
                    end
                endcase
            end
        endcase
    end

    always_comb begin
        cap           = EX_BUBBLE;
        cap.valid     = 1'b1;
        cap.reg_write = id_reg_write;
        cap.mem_read  = id_mem_read;
        cap.mem_write = id_mem_write;
        cap.alu_src   = id_alu_src;
        cap.shift     = dec_shift;
        cap.illegal   = dec_illegal;
        cap.op        = dec_op;
        cap.shamt     = id_shamt;
        cap.rs        = id_rs;
        cap.rt        = id_rt;
        cap.dest      = id_rd;
        cap.rs_val    = id_rs_val;
        cap.rt_val    = id_rt_val;
        cap.imm       = id_imm;
    end

    // Hazard check looks at the live ID fields against the registered load.
    always_comb begin
        load_use_stall = 1'b0;
        if (!flush && ex_q.valid && ex_q.mem_read && ex_q.reg_write &&
            (ex_q.dest != '0) && id_valid &&
            ((id_rs == ex_q.dest) || (id_uses_rt && (id_rt == ex_q.dest))))
            load_use_stall = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ex_q <= EX_BUBBLE;
        else if (flush)
            ex_q <= EX_BUBBLE;
        else if (stall)
            ex_q <= ex_q;
        else if (load_use_stall || !id_valid)
            ex_q <= EX_BUBBLE;
        else
            ex_q <= cap;
    end

    // EX/MEM is younger than MEM/WB, so it is checked first.
    always_comb begin
        fwd_rs = ex_q.rs_val;
        if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == ex_q.rs))
            fwd_rs = exmem_result;
        else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == ex_q.rs))
            fwd_rs = memwb_result;

        fwd_rt = ex_q.rt_val;
        if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == ex_q.rt))
            fwd_rt = exmem_result;
        else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == ex_q.rt))
            fwd_rt = memwb_result;
    end

    // Shifts move rt through in2 and take the amount from in1.
    assign alu_in1       = ex_q.shift ? {{(W-5){1'b0}}, ex_q.shamt} : fwd_rs;
    assign alu_in2       = ex_q.alu_src ? ex_q.imm : fwd_rt;
    assign alu_op        = ex_q.op;
    assign ex_store_data = fwd_rt;
    assign ex_dest       = ex_q.dest;
    assign ex_valid      = ex_q.valid;
    assign ex_reg_write  = ex_q.reg_write;
    assign ex_mem_read   = ex_q.mem_read;
    assign ex_mem_write  = ex_q.mem_write;
    assign illegal_funct = ex_q.illegal;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: decode, forwarding, load-use, stall/flush
// and asynchronous reset, with hand-computed expectations.
module tb_id_ex_stage;

    localparam int W  = 32;
    localparam int RA = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          stall, flush, id_valid;
    logic [W-1:0]  id_rs_val, id_rt_val, id_imm;
    logic [RA-1:0] id_rs, id_rt, id_rd;
    logic [4:0]    id_shamt;
    logic [5:0]    id_funct;
    logic [1:0]    id_alu_class;
    logic          id_alu_src, id_uses_rt, id_reg_write, id_mem_read, id_mem_write;
    logic          exmem_reg_write, memwb_reg_write;
    logic [RA-1:0] exmem_rd, memwb_rd;
    logic [W-1:0]  exmem_result, memwb_result;
    logic [2:0]    alu_op;
    logic signed [W-1:0] alu_in1, alu_in2;
    logic [W-1:0]  ex_store_data;
    logic [RA-1:0] ex_dest;
    logic          ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
    logic          load_use_stall, illegal_funct;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.W(W), .RA(RA)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .id_valid(id_valid), .id_rs_val(id_rs_val), .id_rt_val(id_rt_val),
        .id_imm(id_imm), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_shamt(id_shamt), .id_funct(id_funct), .id_alu_class(id_alu_class),
        .id_alu_src(id_alu_src), .id_uses_rt(id_uses_rt),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write),
        .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd),
        .exmem_result(exmem_result),
        .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd),
        .memwb_result(memwb_result),
        .alu_op(alu_op), .alu_in1(alu_in1), .alu_in2(alu_in2),
        .ex_store_data(ex_store_data), .ex_dest(ex_dest), .ex_valid(ex_valid),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .load_use_stall(load_use_stall),
        .illegal_funct(illegal_funct)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic id_clear();
        id_valid = 0; id_rs_val = '0; id_rt_val = '0; id_imm = '0;
        id_rs = '0; id_rt = '0; id_rd = '0; id_shamt = '0; id_funct = '0;
        id_alu_class = '0; id_alu_src = 0; id_uses_rt = 0;
        id_reg_write = 0; id_mem_read = 0; id_mem_write = 0;
    endtask

    task automatic fwd_clear();
        exmem_reg_write = 0; exmem_rd = '0; exmem_result = '0;
        memwb_reg_write = 0; memwb_rd = '0; memwb_result = '0;
    endtask

    task automatic edge_sample();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 0; stall = 0; flush = 0;
        id_clear();
        fwd_clear();
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1;
        #1;
        check("rst_op", alu_op, 3'b010);
        check("rst_in1", alu_in1, 0);
        check("rst_in2", alu_in2, 0);
        check("rst_valid", ex_valid, 0);
        check("rst_illegal", illegal_funct, 0);
        check("rst_lus", load_use_stall, 0);

        // add, then asynchronous reset mid-cycle
        @(negedge clk);
        id_clear(); id_valid = 1; id_reg_write = 1;
        id_rs = 1; id_rt = 2; id_rd = 3; id_rs_val = 7; id_rt_val = 5;
        edge_sample();
        check("add_op", alu_op, 3'b010);
        check("add_in1", alu_in1, 7);
        check("add_in2", alu_in2, 5);
        check("add_valid", ex_valid, 1);
        check("add_dest", ex_dest, 3);
        #1 rst_n = 0;
        #1;
        check("arst_valid", ex_valid, 0);
        check("arst_op", alu_op, 3'b010);
        check("arst_in1", alu_in1, 0);
        check("arst_rw", ex_reg_write, 0);
        @(negedge clk) rst_n = 1;

        // R-type decode
        id_clear(); id_valid = 1; id_reg_write = 1; id_alu_class = 2'b10;
        id_funct = 6'h22; id_rs = 1; id_rt = 2; id_rd = 3; id_rs_val = 9; id_rt_val = 4;
        edge_sample();
        check("sub_op", alu_op, 3'b110);
        check("sub_in1", alu_in1, 9);
        check("sub_in2", alu_in2, 4);
        check("sub_illegal", illegal_funct, 0);
        @(negedge clk);
        id_funct = 6'h02; id_shamt = 3; id_rs_val = 32'h55; id_rt_val = 32'h80;
        edge_sample();
        check("srl_op", alu_op, 3'b101);
        check("srl_in1", alu_in1, 3);
        check("srl_in2", alu_in2, 32'h80);
        @(negedge clk);
        id_funct = 6'h2A;
        edge_sample();
        check("slt_op", alu_op, 3'b111);
        @(negedge clk);
        id_funct = 6'h3F;
        edge_sample();
        check("ill_op", alu_op, 3'b011);
        check("ill_flag", illegal_funct, 1);
        check("ill_rw", ex_reg_write, 1);

        // id_valid=0 captures a bubble
        @(negedge clk) id_valid = 0;
        edge_sample();
        check("nv_valid", ex_valid, 0);
        check("nv_rw", ex_reg_write, 0);
        check("nv_illegal", illegal_funct, 0);
        check("nv_op", alu_op, 3'b010);

        // forwarding priority
        @(negedge clk);
        id_clear(); id_valid = 1; id_reg_write = 1;
        id_rs = 5; id_rt = 6; id_rd = 7; id_rs_val = 32'h77; id_rt_val = 32'h1;
        edge_sample();
        exmem_reg_write = 1; exmem_rd = 5; exmem_result = 32'h11;
        memwb_reg_write = 1; memwb_rd = 5; memwb_result = 32'h22;
        #1 check("fwd_both", alu_in1, 32'h11);
        exmem_reg_write = 0;
        #1 check("fwd_memwb", alu_in1, 32'h22);
        exmem_reg_write = 1; exmem_rd = 0; memwb_rd = 0;
        #1 check("fwd_zero", alu_in1, 32'h77);
        memwb_rd = 6;
        #1 check("fwd_rt", alu_in2, 32'h22);
        fwd_clear();

        // load-use hazard
        @(negedge clk);
        id_clear(); id_valid = 1; id_reg_write = 1; id_mem_read = 1;
        id_rs = 1; id_rd = 8;
        edge_sample();
        id_clear(); id_valid = 1; id_reg_write = 1; id_rs = 8; id_rt = 9; id_rd = 10;
        id_uses_rt = 1;
        #1 check("lu_rs", load_use_stall, 1);
        edge_sample();
        check("lu_bubble", ex_valid, 0);
        check("lu_after", load_use_stall, 0);
        @(negedge clk);
        id_clear(); id_valid = 1; id_reg_write = 1; id_mem_read = 1;
        id_rs = 1; id_rd = 8;
        edge_sample();
        id_clear(); id_valid = 1; id_rs = 9; id_rt = 8; id_uses_rt = 0;
        #1 check("lu_rt_unused", load_use_stall, 0);
        id_uses_rt = 1;
        #1 check("lu_rt_used", load_use_stall, 1);
        flush = 1;
        #1 check("lu_flush_mask", load_use_stall, 0);
        flush = 0;
        @(negedge clk);
        id_clear(); id_valid = 1; id_reg_write = 1; id_mem_read = 1;
        id_rs = 1; id_rd = 0;
        edge_sample();
        id_clear(); id_valid = 1; id_rs = 0; id_rt = 0; id_uses_rt = 1;
        #1 check("lu_dest0", load_use_stall, 0);

        // stall holds, flush beats stall
        @(negedge clk);
        id_clear(); id_valid = 1; id_reg_write = 1; id_alu_class = 2'b01;
        id_rs = 2; id_rt = 3; id_rd = 4; id_rs_val = 20; id_rt_val = 8;
        edge_sample();
        check("pre_stall_op", alu_op, 3'b110);
        @(negedge clk);
        stall = 1; id_alu_class = 2'b11; id_rs_val = 99; id_rd = 12;
        for (int i = 0; i < 3; i++) begin
            edge_sample();
            check("stall_op", alu_op, 3'b110);
            check("stall_in1", alu_in1, 20);
            check("stall_in2", alu_in2, 8);
            check("stall_dest", ex_dest, 4);
            check("stall_valid", ex_valid, 1);
        end
        @(negedge clk) flush = 1;
        edge_sample();
        check("sf_valid", ex_valid, 0);
        check("sf_op", alu_op, 3'b010);
        check("sf_in1", alu_in1, 0);
        @(negedge clk);
        stall = 0; flush = 0;

        // immediate path with forwarded store data
        id_clear(); id_valid = 1; id_reg_write = 1; id_alu_class = 2'b11; id_alu_src = 1;
        id_imm = 32'hFF; id_rs = 1; id_rt = 7; id_rd = 7; id_rs_val = 32'h3; id_rt_val = 32'h5;
        edge_sample();
        exmem_reg_write = 1; exmem_rd = 7; exmem_result = 32'h1234;
        #1;
        check("imm_op", alu_op, 3'b001);
        check("imm_in2", alu_in2, 32'hFF);
        check("imm_store", ex_store_data, 32'h1234);
        check("imm_in1", alu_in1, 32'h3);
        fwd_clear();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
